// File: rtl/prim_reqack_src_pkg.sv
// Shared types and helpers for the REQ/ACK source-side queue.
// The FSM state and counter sizing live here so the top and any wrappers agree.
package prim_reqack_src_pkg;

   typedef enum logic {
      IdleSt = 1'b0,
      ReqSt  = 1'b1
   } state_e;

   // Counter width able to hold 0..n; a zero bound still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/prim_reqack_src_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read combinationally so
// the consumer can capture it into its own register on the pop cycle.
module prim_reqack_src_fifo #(
   parameter  int unsigned Width  = 8,
   parameter  int unsigned Depth  = 4,
   localparam int unsigned CountW = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [Width-1:0]  wdata_i,
   input  logic              pop_i,
   output logic              full_o,
   output logic              empty_o,
   output logic [CountW-1:0] count_o,
   output logic [Width-1:0]  rdata_o
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    ptr_diff;
   logic [Width-1:0] mem_q [Depth];
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   assign ptr_diff = wptr_q - rptr_q;
   assign count_o  = CountW'(ptr_diff);
   assign rdata_o  = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_ok) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (pop_ok) begin
         rptr_d = rptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/prim_reqack_src_queue.sv
// Source-domain front end of the REQ/ACK synchronizer: buffers producer words and
// presents them one at a time on a held-stable bus while REQ is outstanding.
module prim_reqack_src_queue
   import prim_reqack_src_pkg::*;
#(
   parameter  int unsigned Width         = 8,
   parameter  int unsigned Depth         = 4,
   parameter  int unsigned TimeoutCycles = 0,
   localparam int unsigned DepthW        = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wvalid_i,
   output logic              wready_o,
   input  logic [Width-1:0]  wdata_i,
   output logic              req_o,
   input  logic              ack_i,
   output logic [Width-1:0]  data_o,
   output logic [DepthW-1:0] depth_o,
   output logic              busy_o,
   output logic              timeout_o,
   output logic              proto_err_o
);

   localparam int unsigned TW     = cnt_width(TimeoutCycles);
   localparam logic [TW-1:0] TmoMax = TW'(TimeoutCycles);

   state_e           state_q, state_d;
   logic [Width-1:0] data_q, data_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic             timeout_q, timeout_d;
   logic             proto_err_q, proto_err_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [Width-1:0] fifo_head;

   prim_reqack_src_fifo #(
      .Width (Width),
      .Depth (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (wvalid_i),
      .wdata_i (wdata_i),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (depth_o),
      .rdata_o (fifo_head)
   );

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      tmo_cnt_d   = tmo_cnt_q;
      timeout_d   = timeout_q;
      proto_err_d = proto_err_q;
      fifo_pop    = 1'b0;

      case (state_q)
         IdleSt: begin
            if (ack_i) begin
               proto_err_d = 1'b1;
            end
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               data_d    = fifo_head;
               state_d   = ReqSt;
               tmo_cnt_d = '0;
            end
         end
         ReqSt: begin
            if (ack_i) begin
               tmo_cnt_d = '0;
               // Keep REQ high across back-to-back words; only drop it when drained.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  data_d   = fifo_head;
               end else begin
                  state_d = IdleSt;
               end
            end else if (tmo_cnt_q != TmoMax) begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
      endcase

      if ((TimeoutCycles != 0) && (tmo_cnt_d == TmoMax)) begin
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IdleSt;
         data_q      <= '0;
         tmo_cnt_q   <= '0;
         timeout_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         tmo_cnt_q   <= tmo_cnt_d;
         timeout_q   <= timeout_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign req_o       = (state_q == ReqSt);
   assign data_o      = data_q;
   assign wready_o    = !fifo_full;
   assign busy_o      = req_o || !fifo_empty;
   assign timeout_o   = timeout_q;
   assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_prim_reqack_src_queue.sv
// Bench for prim_reqack_src_queue: cycle-by-cycle vector table plus a data
// scoreboard, then directed timeout, protocol-error and async-reset sequences.
module tb_prim_reqack_src_queue;

   localparam int unsigned Width  = 8;
   localparam int unsigned Depth  = 4;
   localparam int unsigned Tmo    = 16;
   localparam int unsigned DepthW = $clog2(Depth + 1);
   localparam int          NVec   = 26;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              wvalid_i;
   logic              wready_o;
   logic [Width-1:0]  wdata_i;
   logic              req_o;
   logic              ack_i;
   logic [Width-1:0]  data_o;
   logic [DepthW-1:0] depth_o;
   logic              busy_o;
   logic              timeout_o;
   logic              proto_err_o;

   always #5 clk_i = ~clk_i;

   prim_reqack_src_queue #(
      .Width         (Width),
      .Depth         (Depth),
      .TimeoutCycles (Tmo)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wvalid_i    (wvalid_i),
      .wready_o    (wready_o),
      .wdata_i     (wdata_i),
      .req_o       (req_o),
      .ack_i       (ack_i),
      .data_o      (data_o),
      .depth_o     (depth_o),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o),
      .proto_err_o (proto_err_o)
   );

   // Each row: expected outputs at the start of the cycle, then inputs for it.
   typedef struct packed {
      logic       wv;
      logic [7:0] wd;
      logic       ack;
      logic       e_wready;
      logic       e_req;
      logic [7:0] e_data;
      logic [2:0] e_depth;
      logic       e_busy;
   } vec_t;

   vec_t       vecs [NVec];
   logic [7:0] sb_q [$];
   logic       prev_req;
   logic       prev_ack;
   int         n_err = 0;
   int         n_chk = 0;
   int         n_txn = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle; any word newly presented on data_o is matched against the scoreboard.
   task automatic cycle(input logic wv, input logic [7:0] wd, input logic ak);
      logic [7:0] exp_w;
      wvalid_i = wv;
      wdata_i  = wd;
      ack_i    = ak;
      if (wv && wready_o) sb_q.push_back(wd);
      prev_req = req_o;
      prev_ack = ak;
      @(posedge clk_i);
      #1;
      if (req_o && (!prev_req || prev_ack)) begin
         n_txn++;
         if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty: data_o=%0h presented, expected no new word", data_o);
         end else begin
            exp_w = sb_q.pop_front();
            $display("txn %0d: data_o=%0h expected=%0h", n_txn, data_o, exp_w);
            chk("sb_data", {24'd0, data_o}, {24'd0, exp_w});
         end
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},    {31'd0, req_o},       32'd0);
      chk({tag, "_data"},   {24'd0, data_o},      32'd0);
      chk({tag, "_depth"},  {29'd0, depth_o},     32'd0);
      chk({tag, "_busy"},   {31'd0, busy_o},      32'd0);
      chk({tag, "_tmo"},    {31'd0, timeout_o},   32'd0);
      chk({tag, "_perr"},   {31'd0, proto_err_o}, 32'd0);
      chk({tag, "_wready"}, {31'd0, wready_o},    32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i    = 1'b1;
      wvalid_i = 1'b0;
      wdata_i  = '0;
      ack_i    = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;

      // single word, late ack
      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
      vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b1};
      vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b0};
      // burst until full, one rejected write, then pop from full
      vecs[9]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b0};
      vecs[10] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'hA5, 3'd1, 1'b1};
      vecs[11] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1, 1'b1};
      vecs[12] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2, 1'b1};
      vecs[13] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3, 1'b1};
      vecs[14] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1};
      vecs[15] = '{1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1};
      vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1};
      vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3, 1'b1};
      // simultaneous push and pop at depth 2
      vecs[18] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h03, 3'd2, 1'b1};
      vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1};
      vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1};
      vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 3'd1, 1'b1};
      vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 3'd1, 1'b1};
      vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h07, 3'd0, 1'b1};
      vecs[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h07, 3'd0, 1'b1};
      vecs[25] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h07, 3'd0, 1'b0};

      repeat (2) @(posedge clk_i);
      #1;
      chk_reset_vals("rst");
      rst_i = 1'b0;

      for (int i = 0; i < NVec; i++) begin
         chk($sformatf("vec%0d_wready", i), {31'd0, wready_o}, {31'd0, vecs[i].e_wready});
         chk($sformatf("vec%0d_req", i),    {31'd0, req_o},    {31'd0, vecs[i].e_req});
         chk($sformatf("vec%0d_data", i),   {24'd0, data_o},   {24'd0, vecs[i].e_data});
         chk($sformatf("vec%0d_depth", i),  {29'd0, depth_o},  {29'd0, vecs[i].e_depth});
         chk($sformatf("vec%0d_busy", i),   {31'd0, busy_o},   {31'd0, vecs[i].e_busy});
         cycle(vecs[i].wv, vecs[i].wd, vecs[i].ack);
      end
      chk("sb_drained", sb_q.size(), 32'd0);
      chk("vec_tmo_clear",  {31'd0, timeout_o},   32'd0);
      chk("vec_perr_clear", {31'd0, proto_err_o}, 32'd0);

      // timeout: REQ held with no ack
      cycle(1'b1, 8'h3C, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("tmo_req_rise", {31'd0, req_o}, 32'd1);
      chk("tmo_at_rise",  {31'd0, timeout_o}, 32'd0);
      for (int k = 0; k < 15; k++) cycle(1'b0, 8'h00, 1'b0);
      chk("tmo_before_limit", {31'd0, timeout_o}, 32'd0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("tmo_at_limit", {31'd0, timeout_o}, 32'd1);
      cycle(1'b0, 8'h00, 1'b1);
      chk("tmo_req_drop", {31'd0, req_o}, 32'd0);
      chk("tmo_sticky",   {31'd0, timeout_o}, 32'd1);

      // protocol error: ack while idle
      chk("perr_before", {31'd0, proto_err_o}, 32'd0);
      cycle(1'b0, 8'h00, 1'b1);
      chk("perr_set",   {31'd0, proto_err_o}, 32'd1);
      chk("perr_req",   {31'd0, req_o},       32'd0);
      chk("perr_depth", {29'd0, depth_o},     32'd0);
      chk("perr_busy",  {31'd0, busy_o},      32'd0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("perr_sticky", {31'd0, proto_err_o}, 32'd1);

      // asynchronous reset mid-REQ with three words queued
      cycle(1'b1, 8'h11, 1'b0);
      cycle(1'b1, 8'h22, 1'b0);
      cycle(1'b1, 8'h33, 1'b0);
      cycle(1'b1, 8'h44, 1'b0);
      chk("mrst_pre_req",   {31'd0, req_o},   32'd1);
      chk("mrst_pre_depth", {29'd0, depth_o}, 32'd3);
      wvalid_i = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      chk_reset_vals("mrst");
      sb_q.delete();
      prev_req = 1'b0;
      prev_ack = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, 8'h00, 1'b0);
         chk($sformatf("post_rst%0d_req", k),   {31'd0, req_o},   32'd0);
         chk($sformatf("post_rst%0d_depth", k), {29'd0, depth_o}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
